nanoz80_bus_fabric: RTL and testbench

Parametrised Z80 bus interconnect replacing the fixed address decoder and hard-coded priority read-data mux at the top level. Decodes memory and I/O cycles from the tv80 strobes against NUM_SLAVES run-time base/mask windows, and drives one-hot chip selects plus the CPU read-data bus. Adds behaviour the fixed decoder lacks: per-slave programmable wait states, slave-extended ready, open-bus read value, and a bus-timeout error.

---
 rtl/nanoz80_bus_pkg.sv | 16 +
 rtl/nanoz80_bus_match.sv | 43 ++++
 rtl/nanoz80_bus_fabric.sv | 148 ++++++++++++++
 tb/tb_nanoz80_bus_fabric.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanoz80_bus_pkg.sv
// Shared FSM state type and constants for the nanoz80 bus fabric.
// Latency: none; declarations only.
// Backpressure: not applicable.
package nanoz80_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_ERR_HOLD
    } bus_state_t;

    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;
    localparam int         TCNT_W           = 8;

endpackage

// File: rtl/nanoz80_bus_match.sv
// Priority window matcher: lowest-index slave whose base/mask/space matches wins.
// Latency: purely combinational.
// Backpressure: none; result follows the address and space inputs.
module nanoz80_bus_match #(
    parameter int NUM_SLAVES = 8,
    parameter int ADDR_W     = 16,
    parameter int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         io_space,
    input  logic [NUM_SLAVES*ADDR_W-1:0] base,
    input  logic [NUM_SLAVES*ADDR_W-1:0] mask,
    input  logic [NUM_SLAVES-1:0]        slv_io,
    output logic                         hit,
    output logic [IDX_W-1:0]             win_idx,
    output logic [NUM_SLAVES-1:0]        win_oh
);

    logic [NUM_SLAVES-1:0] hit_vec;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit_vec[i] = ((addr & mask[i*ADDR_W +: ADDR_W]) ==
                          (base[i*ADDR_W +: ADDR_W] & mask[i*ADDR_W +: ADDR_W])) &&
                         (slv_io[i] == io_space);
        end
    end

    // Walk downwards so the lowest hitting index is the last one written.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign win_oh = hit_vec & (~hit_vec + 1'b1);
    assign hit    = |hit_vec;

endmodule

// File: rtl/nanoz80_bus_fabric.sv
// Z80 bus interconnect: window decode, chip selects, read mux, wait states; NANOZ80_BUS_TIMEOUT_EN adds bus timeout.
// Latency: selects/read data combinational; wait_n low for detect cycle plus programmed waits until slave ack.
// Backpressure: slave ack and static wait count stall the CPU through wait_n_o.
module nanoz80_bus_fabric
    import nanoz80_bus_pkg::*;
#(
    parameter int                NUM_SLAVES = 8,
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter int                WAIT_W     = 4,
    parameter int                TIMEOUT    = 255,
    parameter logic [DATA_W-1:0] OPEN_BUS   = DATA_W'(OPEN_BUS_DEFAULT)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         mreq_n_i,
    input  logic                         iorq_n_i,
    input  logic                         rd_n_i,
    input  logic                         wr_n_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [NUM_SLAVES*ADDR_W-1:0] slv_base_i,
    input  logic [NUM_SLAVES*ADDR_W-1:0] slv_mask_i,
    input  logic [NUM_SLAVES-1:0]        slv_io_i,
    input  logic [NUM_SLAVES*WAIT_W-1:0] slv_wait_i,
    input  logic [NUM_SLAVES-1:0]        slv_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i,
    output logic [NUM_SLAVES-1:0]        slv_cs_o,
    output logic [DATA_W-1:0]            cpu_din_o,
    output logic                         wait_n_o,
    output logic                         bus_err_o,
    output logic [ADDR_W-1:0]            err_addr_o
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    bus_state_t            state_q, state_d;
    logic                  active, hit, no_wait, last_wait, bus_ok, err_set, tmo;
    logic [IDX_W-1:0]      win_idx, sel_q;
    logic [NUM_SLAVES-1:0] win_oh;
    logic [WAIT_W-1:0]     wait_win, wcnt_q;
    logic [WAIT_W-1:0]     wait_arr  [NUM_SLAVES];
    logic [DATA_W-1:0]     rdata_arr [NUM_SLAVES];

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_unpack
        assign wait_arr[g]  = slv_wait_i[g*WAIT_W +: WAIT_W];
        assign rdata_arr[g] = slv_rdata_i[g*DATA_W +: DATA_W];
    end

    nanoz80_bus_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W)
    ) u_match (
        .addr     (addr_i),
        .io_space (~iorq_n_i),
        .base     (slv_base_i),
        .mask     (slv_mask_i),
        .slv_io   (slv_io_i),
        .hit      (hit),
        .win_idx  (win_idx),
        .win_oh   (win_oh)
    );

    assign active   = ((~mreq_n_i) ^ (~iorq_n_i)) & ((~rd_n_i) | (~wr_n_i));
    assign wait_win = wait_arr[win_idx];
    assign no_wait  = (wait_win == '0) && slv_ack_i[win_idx];
    // The detect cycle already counts as one wait, so the final WAIT cycle is wcnt==1.
    assign last_wait = (wcnt_q <= WAIT_W'(1));

`ifdef NANOZ80_BUS_TIMEOUT_EN
    logic [TCNT_W-1:0] tcnt_q;

    assign tmo = (tcnt_q == TCNT_W'(TIMEOUT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcnt_q     <= '0;
            bus_err_o  <= 1'b0;
            err_addr_o <= '0;
        end else begin
            bus_err_o <= err_set;
            if (err_set) begin
                err_addr_o <= addr_i;
            end
            if (state_q != ST_WAIT) begin
                tcnt_q <= '0;
            end else if (tcnt_q != '1) begin
                tcnt_q <= tcnt_q + 1'b1;
            end
        end
    end
`else
    assign tmo        = 1'b0;
    assign bus_err_o  = 1'b0;
    assign err_addr_o = '0;
`endif

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (active) begin
                    state_d = (hit && !no_wait) ? ST_WAIT : ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (!active) begin
                    state_d = ST_IDLE;
                end else if (last_wait && slv_ack_i[sel_q]) begin
                    state_d = ST_HOLD;
                end else if (tmo) begin
                    state_d = ST_ERR_HOLD;
                    err_set = 1'b1;
                end
            end
            default: begin
                if (!active) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && active && hit) begin
                sel_q  <= win_idx;
                wcnt_q <= wait_win;
            end else if (state_q == ST_WAIT && wcnt_q != '0) begin
                wcnt_q <= wcnt_q - WAIT_W'(1);
            end
        end
    end

    assign bus_ok    = active && !rst_i && (state_q != ST_ERR_HOLD);
    assign slv_cs_o  = bus_ok ? win_oh : '0;
    assign cpu_din_o = (bus_ok && hit && !rd_n_i) ? rdata_arr[win_idx] : OPEN_BUS;
    assign wait_n_o  = rst_i ||
                       !(((state_q == ST_IDLE) && active && hit && !no_wait) ||
                         (state_q == ST_WAIT));

endmodule

// File: tb/tb_nanoz80_bus_fabric.sv
// Directed bench for nanoz80_bus_fabric with a cycle-tagged scoreboard and independent monitors.
module tb_nanoz80_bus_fabric;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         mreq_n_i, iorq_n_i, rd_n_i, wr_n_i;
    logic [15:0]  addr_i;
    logic [127:0] slv_base_i, slv_mask_i;
    logic [7:0]   slv_io_i, slv_ack_i;
    logic [31:0]  slv_wait_i;
    logic [63:0]  slv_rdata_i;
    logic [7:0]   slv_cs_o, cpu_din_o;
    logic         wait_n_o, bus_err_o;
    logic [15:0]  err_addr_o;

    nanoz80_bus_fabric dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mreq_n_i    (mreq_n_i),
        .iorq_n_i    (iorq_n_i),
        .rd_n_i      (rd_n_i),
        .wr_n_i      (wr_n_i),
        .addr_i      (addr_i),
        .slv_base_i  (slv_base_i),
        .slv_mask_i  (slv_mask_i),
        .slv_io_i    (slv_io_i),
        .slv_wait_i  (slv_wait_i),
        .slv_ack_i   (slv_ack_i),
        .slv_rdata_i (slv_rdata_i),
        .slv_cs_o    (slv_cs_o),
        .cpu_din_o   (cpu_din_o),
        .wait_n_o    (wait_n_o),
        .bus_err_o   (bus_err_o),
        .err_addr_o  (err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]  cs;
        logic [7:0]  din;
        logic        wait_n;
        logic        err;
        logic [15:0] eaddr;
    } snap_t;

    snap_t       exp_q[$];
    int          exp_cyc_q[$];
    string       exp_name_q[$];
    int          run_exp_q[$];
    string       run_name_q[$];
    logic [15:0] err_exp_q[$];

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          run_len = 0;
    logic        done = 1'b0;
    logic [15:0] exp_eaddr = 16'h0000;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic expect_now(input string name, input logic [7:0] cs, input logic [7:0] din,
                              input logic wn, input logic err);
        snap_t s;
        s.cs = cs; s.din = din; s.wait_n = wn; s.err = err; s.eaddr = exp_eaddr;
        exp_q.push_back(s);
        exp_cyc_q.push_back(cyc);
        exp_name_q.push_back(name);
    endtask

    task automatic run_push(input int len, input string name);
        run_exp_q.push_back(len);
        run_name_q.push_back(name);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic io, input logic rd);
        addr_i = a; mreq_n_i = io; iorq_n_i = !io; rd_n_i = !rd; wr_n_i = rd;
    endtask

    task automatic release_bus();
        mreq_n_i = 1'b1; iorq_n_i = 1'b1; rd_n_i = 1'b1; wr_n_i = 1'b1;
    endtask

    task automatic set_slave(input int i, input logic [15:0] b, input logic [15:0] m,
                             input logic io, input logic [3:0] w, input logic [7:0] d);
        slv_base_i[i*16 +: 16] = b;
        slv_mask_i[i*16 +: 16] = m;
        slv_io_i[i]            = io;
        slv_wait_i[i*4 +: 4]   = w;
        slv_rdata_i[i*8 +: 8]  = d;
    endtask

    // Monitor: snapshot scoreboard, wait_n low-run lengths, and bus_err pulses.
    always @(negedge clk_i) begin
        snap_t       act, e;
        int          c, re;
        string       n;
        logic [15:0] ea;
        act.cs = slv_cs_o; act.din = cpu_din_o; act.wait_n = wait_n_o;
        act.err = bus_err_o; act.eaddr = err_addr_o;
        while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
            e = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            n = exp_name_q.pop_front();
            checks++;
            if (c != cyc) begin
                errors++;
                $display("FAIL %s: sample missed, tagged cycle %0d seen at %0d", n, c, cyc);
            end else if (act !== e) begin
                errors++;
                $display("FAIL %s: got cs=%h din=%h wait_n=%b err=%b eaddr=%h, want cs=%h din=%h wait_n=%b err=%b eaddr=%h",
                         n, act.cs, act.din, act.wait_n, act.err, act.eaddr,
                         e.cs, e.din, e.wait_n, e.err, e.eaddr);
            end
        end
        if (wait_n_o !== 1'b1) begin
            run_len++;
        end else if (run_len > 0) begin
            checks++;
            if (run_exp_q.size() == 0) begin
                errors++;
                $display("FAIL wait_run: got unexpected low run of %0d cycles, want none", run_len);
            end else begin
                re = run_exp_q.pop_front();
                n  = run_name_q.pop_front();
                if (re != run_len) begin
                    errors++;
                    $display("FAIL %s: wait_n low for %0d cycles, want %0d", n, run_len, re);
                end
            end
            run_len = 0;
        end
        if (bus_err_o !== 1'b0) begin
            checks++;
            if (err_exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_err: got unexpected pulse (value %b), want none", bus_err_o);
            end else begin
                ea = err_exp_q.pop_front();
                if (err_addr_o !== ea) begin
                    errors++;
                    $display("FAIL err_addr: got %h, want %h", err_addr_o, ea);
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL snapshots_left: got %0d pending, want 0", exp_q.size());
            end
            checks++;
            if (run_exp_q.size() != 0 || run_len != 0) begin
                errors++;
                $display("FAIL wait_runs_left: got %0d pending (open run %0d), want 0", run_exp_q.size(), run_len);
            end
            checks++;
            if (err_exp_q.size() != 0) begin
                errors++;
                $display("FAIL err_pulses_left: got %0d pending, want 0", err_exp_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        rst_i = 1'b1;
        release_bus();
        addr_i      = 16'h0000;
        slv_ack_i   = 8'hFF;
        slv_base_i  = '0; slv_mask_i = '0; slv_io_i = '0; slv_wait_i = '0; slv_rdata_i = '0;
        set_slave(0, 16'h0000, 16'hE000, 1'b0, 4'd0, 8'hA0);
        set_slave(1, 16'h0000, 16'hC000, 1'b0, 4'd0, 8'hA1);
        set_slave(2, 16'h0000, 16'h0000, 1'b0, 4'd0, 8'hA2);
        set_slave(3, 16'h0040, 16'h00FF, 1'b1, 4'd3, 8'hA3);
        set_slave(4, 16'h4000, 16'hF000, 1'b0, 4'd0, 8'hA4);
        set_slave(5, 16'h0080, 16'h00FF, 1'b1, 4'd1, 8'hA5);
        set_slave(6, 16'hFFFF, 16'hFFFF, 1'b1, 4'd0, 8'hA6);
        set_slave(7, 16'hFFFF, 16'hFFFF, 1'b1, 4'd0, 8'hA7);

        step(); expect_now("reset", 8'h00, 8'hFF, 1'b1, 1'b0);
        step(); step(); rst_i = 1'b0;
        step(); expect_now("idle_after_reset", 8'h00, 8'hFF, 1'b1, 1'b0);

        // Zero-wait memory read and write on slave 1
        step(); bus(16'h2000, 1'b0, 1'b1); expect_now("mem_rd_s1", 8'h02, 8'hA1, 1'b1, 1'b0);
        step(); expect_now("mem_rd_s1_hold", 8'h02, 8'hA1, 1'b1, 1'b0);
        step(); release_bus(); expect_now("mem_rd_s1_release", 8'h00, 8'hFF, 1'b1, 1'b0);
        step(); bus(16'h3FFF, 1'b0, 1'b0); expect_now("mem_wr_s1", 8'h02, 8'hFF, 1'b1, 1'b0);
        step(); release_bus();

        // Overlapping windows: slave 0 beats catch-all slave 2
        step(); bus(16'h0100, 1'b0, 1'b1); expect_now("overlap_s0", 8'h01, 8'hA0, 1'b1, 1'b0);
        step(); release_bus();
        set_slave(2, 16'h8000, 16'hFFFF, 1'b0, 4'd0, 8'hA2);
        step(); bus(16'h8000, 1'b0, 1'b1); expect_now("exact_s2", 8'h04, 8'hA2, 1'b1, 1'b0);
        step(); release_bus();

        // I/O write, three static waits
        step(); bus(16'h1240, 1'b1, 1'b0); run_push(4, "io_wr_s3_wait");
        for (int k = 0; k < 6; k++) begin
            expect_now("io_wr_s3", 8'h08, 8'hFF, (k >= 4), 1'b0);
            step();
        end
        release_bus(); expect_now("io_wr_s3_done", 8'h00, 8'hFF, 1'b1, 1'b0);

        // I/O read, single static wait
        step(); bus(16'h0080, 1'b1, 1'b1); run_push(2, "io_rd_s5_wait");
        for (int k = 0; k < 4; k++) begin
            expect_now("io_rd_s5", 8'h20, 8'hA5, (k >= 2), 1'b0);
            step();
        end
        release_bus();

        // Slave-extended ready: ack low for 10 cycles
        slv_ack_i[4] = 1'b0;
        step(); bus(16'h4000, 1'b0, 1'b1); run_push(11, "ack_late_s4_wait");
        for (int k = 0; k < 13; k++) begin
            if (k == 10) slv_ack_i[4] = 1'b1;
            expect_now("ack_late_s4", 8'h10, 8'hA4, (k >= 11), 1'b0);
            step();
        end
        release_bus();

        // Unmapped accesses and both space strobes low
        step(); bus(16'hC000, 1'b0, 1'b1); expect_now("unmapped_rd", 8'h00, 8'hFF, 1'b1, 1'b0);
        step(); expect_now("unmapped_rd_hold", 8'h00, 8'hFF, 1'b1, 1'b0);
        step(); release_bus();
        step(); bus(16'h0010, 1'b1, 1'b0); expect_now("unmapped_io_wr", 8'h00, 8'hFF, 1'b1, 1'b0);
        step(); release_bus();
        step(); addr_i = 16'h2000; mreq_n_i = 1'b0; iorq_n_i = 1'b0; rd_n_i = 1'b0;
        expect_now("both_space_low", 8'h00, 8'hFF, 1'b1, 1'b0);
        step(); release_bus();

        // Ack stuck low
        slv_ack_i[4] = 1'b0;
        step(); bus(16'h4123, 1'b0, 1'b1);
        expect_now("stuck_start", 8'h10, 8'hA4, 1'b0, 1'b0);
`ifdef NANOZ80_BUS_TIMEOUT_EN
        run_push(257, "timeout_wait");
        err_exp_q.push_back(16'h4123);
        repeat (257) step();
        exp_eaddr = 16'h4123;
        expect_now("timeout_err_hold", 8'h00, 8'hFF, 1'b1, 1'b1);
        step(); expect_now("timeout_err_done", 8'h00, 8'hFF, 1'b1, 1'b0);
        step(); release_bus();
`else
        run_push(301, "no_timeout_wait");
        repeat (257) step();
        expect_now("no_timeout_still_waiting", 8'h10, 8'hA4, 1'b0, 1'b0);
        repeat (43) step();
        release_bus(); expect_now("abort_in_wait", 8'h00, 8'hFF, 1'b0, 1'b0);
`endif
        step(); expect_now("after_stuck_idle", 8'h00, 8'hFF, 1'b1, 1'b0);
        slv_ack_i[4] = 1'b1;

        // Reset asserted mid-WAIT
        slv_ack_i[4] = 1'b0;
        step(); bus(16'h4000, 1'b0, 1'b1); run_push(3, "rst_wait");
        expect_now("rst_wait_start", 8'h10, 8'hA4, 1'b0, 1'b0);
        step(); step();
        step(); rst_i = 1'b1; expect_now("rst_asserted", 8'h00, 8'hFF, 1'b1, 1'b0);
        step(); exp_eaddr = 16'h0000; expect_now("rst_idle", 8'h00, 8'hFF, 1'b1, 1'b0);
        release_bus(); rst_i = 1'b0; slv_ack_i[4] = 1'b1;
        step(); bus(16'h2000, 1'b0, 1'b1); expect_now("post_rst_rd_s1", 8'h02, 8'hA1, 1'b1, 1'b0);
        step(); release_bus();
        step(); expect_now("final_idle", 8'h00, 8'hFF, 1'b1, 1'b0);
        step();
        done = 1'b1;
    end

endmodule
